mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr_if.sv | 32 +++
 rtl/mem_arbiter_rr.sv | 72 +++++++
 tb/tb_mem_arbiter_rr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: shared-memory request/response types and the arbiter bus bundle.
package mem_arbiter_rr_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;
    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;
endpackage

interface mem_arbiter_rr_if
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NPORT = 2
);
    localparam int OW = NPORT > 1 ? $clog2(NPORT) : 1;
    mem_in_type  [NPORT-1:0] req_in;
    mem_out_type [NPORT-1:0] req_out;
    mem_in_type              mem_in;
    mem_out_type             mem_out;
    logic [OW-1:0]           owner;
    logic                    busy;
    logic [NPORT-1:0]        pending;
    modport slave (input req_in, mem_out, output req_out, mem_in, owner, busy, pending);
    modport master (output req_in, mem_out, input req_out, mem_in, owner, busy, pending);
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port shared-memory arbiter with per-port pending latches,
// round-robin or fixed priority, zero-latency and back-to-back issue.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NPORT     = 2,
    parameter int PRIO_MODE = 0
) (
    input logic             clock,
    input logic             reset,
    mem_arbiter_rr_if.slave bus
);
    localparam int OW = NPORT > 1 ? $clog2(NPORT) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t                 state, state_nxt;
    mem_in_type [NPORT-1:0] lat, lat_nxt, eff;
    mem_in_type             issued, issued_nxt;
    logic [OW-1:0]          owner, owner_nxt, last, last_nxt, win, base, cand;
    logic [NPORT-1:0]       eff_v;
    logic                   free, grant;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            lat    <= '0;
            issued <= init_mem_in;
            owner  <= '0;
            last   <= OW'(NPORT - 1);
        end else begin
            state  <= state_nxt;
            lat    <= lat_nxt;
            issued <= issued_nxt;
            owner  <= owner_nxt;
            last   <= last_nxt;
        end
    end

    // Fixed priority is round-robin with the scan always starting just past NPORT-1.
    always_comb begin
        free = state == IDLE || bus.mem_out.mem_ready;
        base = PRIO_MODE != 0 ? OW'(NPORT - 1) : last;
        win  = '0;
        cand = '0;
        for (int i = 0; i < NPORT; i++) begin
            eff[i]   = bus.req_in[i].mem_valid ? bus.req_in[i] : lat[i];
            eff_v[i] = eff[i].mem_valid;
        end
        for (int k = NPORT; k >= 1; k--) begin
            cand = OW'((int'(base) + k) % NPORT);
            win  = eff_v[cand] ? cand : win;
        end
        grant      = free && |eff_v;
        state_nxt  = grant ? BUSY : free ? IDLE : state;
        issued_nxt = grant ? eff[win] : free ? init_mem_in : issued;
        owner_nxt  = grant ? win : free ? '0 : owner;
        last_nxt   = grant ? win : last;
        for (int i = 0; i < NPORT; i++)
            lat_nxt[i] = grant && win == OW'(i) ? init_mem_in : eff[i];
    end

    always_comb begin
        bus.busy    = state == BUSY;
        bus.owner   = owner;
        bus.pending = '0;
        bus.req_out = '0;
        bus.mem_in  = !reset ? init_mem_in : grant ? eff[win] : state == BUSY ? issued : init_mem_in;
        for (int i = 0; i < NPORT; i++) begin
            bus.pending[i] = lat[i].mem_valid;
            bus.req_out[i] = reset && state == BUSY && owner == OW'(i) ? bus.mem_out : init_mem_out;
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed checks of a 2-port fixed-priority and a 3-port
// round-robin arbiter instance sharing one clock and reset.
module tb_mem_arbiter_rr;
    import mem_arbiter_rr_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clock = ~clock;

    mem_arbiter_rr_if #(.NPORT(2)) b2();
    mem_arbiter_rr_if #(.NPORT(3)) b3();
    mem_arbiter_rr #(.NPORT(2), .PRIO_MODE(1)) dut2 (.clock(clock), .reset(reset), .bus(b2));
    mem_arbiter_rr #(.NPORT(3), .PRIO_MODE(0)) dut3 (.clock(clock), .reset(reset), .bus(b3));

    function automatic mem_in_type mk(logic [31:0] a);
        return '{mem_valid: 1'b1, mem_addr: a, mem_wdata: ~a, mem_wstrb: 4'hF};
    endfunction

    task automatic clear_inputs;
        b2.req_in  = '0;
        b3.req_in  = '0;
        b2.mem_out = '0;
        b3.mem_out = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b0;
        b3.req_in[0] = mk(32'h44);
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (b3.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", b3.busy); end
        n_cmp++; if (b3.pending !== 3'b000) begin n_bad++; $display("FAIL reset_pending: got %b want 000", b3.pending); end
        n_cmp++; if (b3.owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", b3.owner); end
        n_cmp++; if (b3.mem_in !== init_mem_in) begin n_bad++; $display("FAIL reset_mem_in: got %h want 0", b3.mem_in); end
        n_cmp++; if (b2.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy2: got %0b want 0", b2.busy); end
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic test_prio;
        @(negedge clock);
        b2.req_in[0] = mk(32'h10);
        b2.req_in[1] = mk(32'h20);
        #1;
        n_cmp++; if (b2.mem_in !== mk(32'h10)) begin n_bad++; $display("FAIL prio_issue0: got %h want %h", b2.mem_in, mk(32'h10)); end
        @(negedge clock);
        b2.req_in = '0;
        #1;
        n_cmp++; if (b2.busy !== 1'b1 || b2.owner !== 1'b0) begin n_bad++; $display("FAIL prio_owner0: got busy %0b owner %0d want 1/0", b2.busy, b2.owner); end
        n_cmp++; if (b2.pending !== 2'b10) begin n_bad++; $display("FAIL prio_pending: got %b want 10", b2.pending); end
        n_cmp++; if (b2.mem_in !== mk(32'h10)) begin n_bad++; $display("FAIL prio_hold0: got %h want %h", b2.mem_in, mk(32'h10)); end
        b2.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h1234};
        #1;
        n_cmp++; if (b2.mem_in !== mk(32'h20)) begin n_bad++; $display("FAIL prio_b2b: got %h want %h", b2.mem_in, mk(32'h20)); end
        n_cmp++; if ({b2.req_out[1].mem_ready, b2.req_out[0].mem_ready} !== 2'b01) begin n_bad++; $display("FAIL prio_ready: got %b want 01", {b2.req_out[1].mem_ready, b2.req_out[0].mem_ready}); end
        @(negedge clock);
        b2.mem_out = '0;
        #1;
        n_cmp++; if (b2.busy !== 1'b1 || b2.owner !== 1'b1 || b2.pending !== 2'b00) begin n_bad++; $display("FAIL prio_owner1: got busy %0b owner %0d pending %b want 1/1/00", b2.busy, b2.owner, b2.pending); end
        b2.mem_out.mem_ready = 1'b1;
        @(negedge clock);
        b2.mem_out = '0;
        #1;
        n_cmp++; if (b2.busy !== 1'b0) begin n_bad++; $display("FAIL prio_idle: got %0b want 0", b2.busy); end
    endtask

    task automatic test_rr;
        int exp_o[6] = '{0, 1, 2, 0, 1, 2};
        @(negedge clock);
        for (int i = 0; i < 3; i++) b3.req_in[i] = mk(32'h1000 + 32'(i) * 16);
        #1;
        n_cmp++; if (b3.mem_in !== mk(32'h1000)) begin n_bad++; $display("FAIL rr_first: got %h want %h", b3.mem_in, mk(32'h1000)); end
        for (int n = 1; n < 6; n++) begin
            @(negedge clock);
            b3.mem_out.mem_ready = 1'b0;
            #1;
            n_cmp++; if (b3.owner !== 2'(exp_o[n-1]) || b3.busy !== 1'b1) begin n_bad++; $display("FAIL rr_owner%0d: got %0d want %0d", n - 1, b3.owner, exp_o[n-1]); end
            @(negedge clock);
            b3.mem_out.mem_ready = 1'b1;
            #1;
            n_cmp++; if (b3.mem_in !== mk(32'h1000 + 32'(exp_o[n]) * 16)) begin n_bad++; $display("FAIL rr_grant%0d: got %h want %h", n, b3.mem_in, mk(32'h1000 + 32'(exp_o[n]) * 16)); end
        end
        @(negedge clock);
        b3.mem_out.mem_ready = 1'b0;
        #1;
        n_cmp++; if (b3.owner !== 2'd2) begin n_bad++; $display("FAIL rr_owner5: got %0d want 2", b3.owner); end
        b3.req_in = '0;
        b3.mem_out.mem_ready = 1'b1;
        repeat (4) @(negedge clock);
        b3.mem_out = '0;
        #1;
        n_cmp++; if (b3.busy !== 1'b0 || b3.pending !== 3'b000) begin n_bad++; $display("FAIL rr_drain: got busy %0b pending %b want 0/000", b3.busy, b3.pending); end
    endtask

    task automatic test_single;
        @(negedge clock);
        b3.req_in[2] = mk(32'h2000);
        #1;
        n_cmp++; if (b3.mem_in !== mk(32'h2000)) begin n_bad++; $display("FAIL single_zero_lat: got %h want %h", b3.mem_in, mk(32'h2000)); end
        @(negedge clock);
        b3.req_in[2] = '0;
        #1;
        n_cmp++; if (b3.busy !== 1'b1 || b3.owner !== 2'd2) begin n_bad++; $display("FAIL single_owner: got busy %0b owner %0d want 1/2", b3.busy, b3.owner); end
        b3.mem_out.mem_ready = 1'b1;
        @(negedge clock);
        b3.mem_out = '0;
        #1;
        n_cmp++; if (b3.busy !== 1'b0) begin n_bad++; $display("FAIL single_done: got %0b want 0", b3.busy); end
    endtask

    task automatic test_overwrite;
        @(negedge clock);
        b3.req_in[1] = mk(32'h80);
        @(negedge clock);
        b3.req_in[1] = mk(32'h100);
        #1;
        n_cmp++; if (b3.busy !== 1'b1 || b3.owner !== 2'd1) begin n_bad++; $display("FAIL ovw_owner: got busy %0b owner %0d want 1/1", b3.busy, b3.owner); end
        @(negedge clock);
        b3.req_in[1] = mk(32'h104);
        #1;
        n_cmp++; if (b3.pending !== 3'b010) begin n_bad++; $display("FAIL ovw_pending: got %b want 010", b3.pending); end
        @(negedge clock);
        b3.req_in[1] = '0;
        #1;
        n_cmp++; if (b3.mem_in !== mk(32'h80)) begin n_bad++; $display("FAIL ovw_hold: got %h want %h", b3.mem_in, mk(32'h80)); end
        b3.mem_out.mem_ready = 1'b1;
        #1;
        n_cmp++; if (b3.mem_in !== mk(32'h104)) begin n_bad++; $display("FAIL ovw_newest: got %h want %h", b3.mem_in, mk(32'h104)); end
        @(negedge clock);
        b3.mem_out = '0;
        #1;
        n_cmp++; if (b3.owner !== 2'd1 || b3.pending !== 3'b000 || b3.mem_in !== mk(32'h104)) begin n_bad++; $display("FAIL ovw_issued: got owner %0d pending %b mem_in %h want 1/000/%h", b3.owner, b3.pending, b3.mem_in, mk(32'h104)); end
        b3.mem_out.mem_ready = 1'b1;
        @(negedge clock);
        b3.mem_out = '0;
        #1;
        n_cmp++; if (b3.busy !== 1'b0) begin n_bad++; $display("FAIL ovw_done: got %0b want 0", b3.busy); end
    endtask

    task automatic test_route;
        mem_out_type rsp = '{mem_ready: 1'b1, mem_rdata: 32'hDEADBEEF};
        @(negedge clock);
        b3.req_in[2] = mk(32'h300);
        @(negedge clock);
        b3.req_in[2] = '0;
        b3.mem_out = rsp;
        #1;
        n_cmp++; if (b3.owner !== 2'd2 || b3.busy !== 1'b1) begin n_bad++; $display("FAIL route_owner: got %0d want 2", b3.owner); end
        n_cmp++; if (b3.req_out[2] !== rsp) begin n_bad++; $display("FAIL route_owner_rsp: got %h want %h", b3.req_out[2], rsp); end
        n_cmp++; if (b3.req_out[0] !== init_mem_out || b3.req_out[1] !== init_mem_out) begin n_bad++; $display("FAIL route_others: got %h %h want 0 0", b3.req_out[0], b3.req_out[1]); end
        @(negedge clock);
        #1;
        n_cmp++; if (b3.busy !== 1'b0 || b3.req_out !== '0) begin n_bad++; $display("FAIL route_idle_ready: got busy %0b req_out %h want 0/0", b3.busy, b3.req_out); end
        b3.mem_out = '0;
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        b3.req_in[2] = mk(32'h400);
        @(negedge clock);
        b3.req_in[2] = '0;
        b3.req_in[0] = mk(32'h500);
        b3.req_in[1] = mk(32'h504);
        @(negedge clock);
        b3.req_in = '0;
        #1;
        n_cmp++; if (b3.busy !== 1'b1 || b3.pending !== 3'b011) begin n_bad++; $display("FAIL rstmid_setup: got busy %0b pending %b want 1/011", b3.busy, b3.pending); end
        reset = 1'b0;
        @(negedge clock);
        #1;
        n_cmp++; if (b3.busy !== 1'b0 || b3.pending !== 3'b000 || b3.owner !== 2'd0) begin n_bad++; $display("FAIL rstmid_state: got busy %0b pending %b owner %0d want 0/000/0", b3.busy, b3.pending, b3.owner); end
        n_cmp++; if (b3.mem_in !== init_mem_in) begin n_bad++; $display("FAIL rstmid_mem_in: got %h want 0", b3.mem_in); end
        reset = 1'b1;
        b3.mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hCAFE};
        @(negedge clock);
        #1;
        n_cmp++; if ({b3.req_out[2].mem_ready, b3.req_out[1].mem_ready, b3.req_out[0].mem_ready} !== 3'b000 || b3.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_ready: got ready %b busy %0b want 000/0", {b3.req_out[2].mem_ready, b3.req_out[1].mem_ready, b3.req_out[0].mem_ready}, b3.busy); end
        b3.mem_out = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_prio();
        test_rr();
        test_single();
        test_overwrite();
        test_route();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
